// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator command path.
package calc_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_HALT = 8'h03;

    typedef enum logic [2:0] {
        StIdle,
        StFetchOpnd,
        StFetchOp,
        StIssue,
        StFinish
    } fetch_state_t;

endpackage

// File: rtl/calc_cmd_fetch_if.sv
// Bundle between the command fetcher, the command SRAM read port and the ALU.
interface calc_cmd_fetch_if
    import calc_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              start;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_opcode;
    logic [DATA_W-1:0] cmd_operand;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, rd_data, cmd_ready,
        output rd_addr, cmd_valid, cmd_opcode, cmd_operand, busy, done, error
    );

    modport slave (
        output start, rd_data, cmd_ready,
        input  rd_addr, cmd_valid, cmd_opcode, cmd_operand, busy, done, error
    );

endinterface

// File: rtl/calc_cmd_fetch.sv
// Walks command SRAM two bytes at a time (operand, opcode) and issues ADD/SUB to the ALU.
module calc_cmd_fetch
    import calc_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned LAST_ADDR = 127
) (
    input logic              clk,
    input logic              reset_n,
    calc_cmd_fetch_if.master bus
);

    localparam logic [ADDR_W-1:0] BaseA = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastA = ADDR_W'(LAST_ADDR);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic              error_q, error_d;

    logic              at_last;
    logic [ADDR_W-1:0] pc_inc;

    // Overrun is checked before incrementing so pc never wraps.
    assign at_last = (pc_q >= LastA);
    assign pc_inc  = pc_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pc_q      <= BaseA;
            opcode_q  <= '0;
            operand_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        error_d   = error_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    pc_d    = BaseA;
                    error_d = 1'b0;
                    state_d = StFetchOpnd;
                end
            end
            StFetchOpnd: begin
                operand_d = bus.rd_data;
                if (at_last) begin
                    error_d = 1'b1;
                    state_d = StFinish;
                end else begin
                    pc_d    = pc_inc;
                    state_d = StFetchOp;
                end
            end
            StFetchOp: begin
                opcode_d = bus.rd_data;
                if (bus.rd_data == DATA_W'(OP_ADD) || bus.rd_data == DATA_W'(OP_SUB)) begin
                    state_d = StIssue;
                end else if (bus.rd_data == DATA_W'(OP_NOP)) begin
                    if (at_last) begin
                        error_d = 1'b1;
                        state_d = StFinish;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = StFetchOpnd;
                    end
                end else if (bus.rd_data == DATA_W'(OP_HALT)) begin
                    state_d = StFinish;
                end else begin
                    error_d = 1'b1;
                    state_d = StFinish;
                end
            end
            StIssue: begin
                if (bus.cmd_ready) begin
                    if (at_last) begin
                        error_d = 1'b1;
                        state_d = StFinish;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = StFetchOpnd;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign bus.rd_addr     = pc_q;
    assign bus.cmd_valid   = (state_q == StIssue);
    assign bus.cmd_opcode  = opcode_q;
    assign bus.cmd_operand = operand_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StFinish);
    assign bus.error       = error_q;

endmodule

// File: tb/tb_calc_cmd_fetch.sv
// Directed bench for calc_cmd_fetch: one default instance, one with a short memory.
module tb_calc_cmd_fetch;

    logic       clk;
    logic       reset_n;
    logic [7:0] mem [0:255];

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] q_op[$];
    logic [7:0] q_opnd[$];
    int         cnt1 = 0;
    int         max1 = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_op, hold_opnd;

    calc_cmd_fetch_if #(.ADDR_W(8), .DATA_W(8)) f0 ();
    calc_cmd_fetch_if #(.ADDR_W(8), .DATA_W(8)) f1 ();

    assign f0.rd_data = mem[f0.rd_addr];
    assign f1.rd_data = mem[f1.rd_addr];

    calc_cmd_fetch #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(0), .LAST_ADDR(127)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (f0)
    );

    calc_cmd_fetch #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(0), .LAST_ADDR(9)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (f1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Handshakes are recorded at the negedge before the edge that completes them.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", f0.cmd_valid, 1);
                check("hold_opcode", f0.cmd_opcode, hold_op);
                check("hold_operand", f0.cmd_operand, hold_opnd);
            end
            if (f0.cmd_valid && f0.cmd_ready) begin
                q_op.push_back(f0.cmd_opcode);
                q_opnd.push_back(f0.cmd_operand);
            end
            hold_v    = f0.cmd_valid && !f0.cmd_ready;
            hold_op   = f0.cmd_opcode;
            hold_opnd = f0.cmd_operand;
            if (f1.cmd_valid && f1.cmd_ready) cnt1++;
            if (int'(f1.rd_addr) > max1) max1 = int'(f1.rd_addr);
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h06; mem[3] = 8'h01;
        mem[4] = 8'h02; mem[5] = 8'h01; mem[6] = 8'h0A; mem[7] = 8'h01;
        mem[8] = 8'h0E; mem[9] = 8'h03;
    endtask

    task automatic pulse_start(input int which);
        @(posedge clk); #1;
        if (which == 0) f0.start = 1'b1; else f1.start = 1'b1;
        @(posedge clk); #1;
        f0.start = 1'b0;
        f1.start = 1'b0;
    endtask

    // Waits for done, then checks it lasts one cycle and busy falls with it.
    task automatic wait_done(input int which, input string tag);
        logic seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            seen = (which == 0) ? f0.done : f1.done;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_busy_in_finish"}, (which == 0) ? f0.busy : f1.busy, 1);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, (which == 0) ? f0.done : f1.done, 0);
            check({tag, "_busy_after"}, (which == 0) ? f0.busy : f1.busy, 0);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        f0.start     = 1'b0;
        f1.start     = 1'b0;
        f0.cmd_ready = 1'b1;
        f1.cmd_ready = 1'b1;
        clear_mem();
        #3;
        check("rst_rd_addr", f0.rd_addr, 0);
        check("rst_valid", f0.cmd_valid, 0);
        check("rst_opcode", f0.cmd_opcode, 0);
        check("rst_operand", f0.cmd_operand, 0);
        check("rst_busy", f0.busy, 0);
        check("rst_done", f0.done, 0);
        check("rst_error", f0.error, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Four ADDs then HALT, ALU always ready.
        load_prog1();
        q_op.delete(); q_opnd.delete();
        pulse_start(0);
        @(negedge clk);
        check("t1_busy_n1", f0.busy, 1);
        check("t1_valid_n1", f0.cmd_valid, 0);
        @(negedge clk);
        check("t1_valid_n2", f0.cmd_valid, 0);
        @(negedge clk);
        check("t1_valid_n3", f0.cmd_valid, 1);
        wait_done(0, "t1");
        check("t1_count", q_opnd.size(), 4);
        if (q_opnd.size() == 4) begin
            check("t1_opnd0", q_opnd[0], 8'h00);
            check("t1_opnd1", q_opnd[1], 8'h06);
            check("t1_opnd2", q_opnd[2], 8'h02);
            check("t1_opnd3", q_opnd[3], 8'h0A);
            check("t1_op3", q_op[3], 8'h01);
        end
        check("t1_error", f0.error, 0);

        // Same program, ALU stalls the second command for four cycles.
        q_op.delete(); q_opnd.delete();
        pulse_start(0);
        for (int n = 0; n < 50 && q_opnd.size() < 1; n++) @(negedge clk);
        check("t2_first_seen", q_opnd.size(), 1);
        @(posedge clk); #1;
        f0.cmd_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t2_stall_valid", f0.cmd_valid, 1);
        check("t2_stall_operand", f0.cmd_operand, 8'h06);
        check("t2_stall_opcode", f0.cmd_opcode, 8'h01);
        @(posedge clk); #1;
        f0.cmd_ready = 1'b1;
        wait_done(0, "t2");
        check("t2_count", q_opnd.size(), 4);
        if (q_opnd.size() == 4) begin
            check("t2_opnd1", q_opnd[1], 8'h06);
            check("t2_opnd2", q_opnd[2], 8'h02);
        end

        // NOP skipped, SUB issued, HALT.
        clear_mem();
        mem[0] = 8'h05; mem[1] = 8'h00; mem[2] = 8'h07;
        mem[3] = 8'h02; mem[4] = 8'h00; mem[5] = 8'h03;
        q_op.delete(); q_opnd.delete();
        pulse_start(0);
        wait_done(0, "t3");
        check("t3_count", q_opnd.size(), 1);
        if (q_opnd.size() == 1) begin
            check("t3_op", q_op[0], 8'h02);
            check("t3_opnd", q_opnd[0], 8'h07);
        end
        check("t3_error", f0.error, 0);

        // Illegal opcode, then a fresh start clears error.
        clear_mem();
        mem[0] = 8'h09; mem[1] = 8'h7F;
        q_op.delete(); q_opnd.delete();
        pulse_start(0);
        wait_done(0, "t4");
        check("t4_count", q_opnd.size(), 0);
        check("t4_error", f0.error, 1);
        pulse_start(0);
        @(negedge clk);
        check("t4_error_cleared", f0.error, 0);
        wait_done(0, "t4b");
        check("t4b_error", f0.error, 1);

        // All NOPs with LAST_ADDR = 9: overrun.
        clear_mem();
        max1 = 0;
        cnt1 = 0;
        pulse_start(1);
        wait_done(1, "t5");
        check("t5_error", f1.error, 1);
        check("t5_max_addr", max1, 9);
        check("t5_count", cnt1, 0);

        // Stall in ISSUE, ignored start, then reset mid-run.
        load_prog1();
        q_op.delete(); q_opnd.delete();
        f0.cmd_ready = 1'b0;
        pulse_start(0);
        repeat (3) @(negedge clk);
        check("t6_valid", f0.cmd_valid, 1);
        check("t6_rd_addr", f0.rd_addr, 1);
        pulse_start(0);
        @(negedge clk);
        check("t6_start_ignored_valid", f0.cmd_valid, 1);
        check("t6_start_ignored_addr", f0.rd_addr, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", f0.cmd_valid, 0);
        check("t6_rst_busy", f0.busy, 0);
        check("t6_rst_rd_addr", f0.rd_addr, 0);
        check("t6_rst_opcode", f0.cmd_opcode, 0);
        check("t6_rst_operand", f0.cmd_operand, 0);
        check("t6_rst_done", f0.done, 0);
        check("t6_rst_error", f0.error, 0);
        check("t6_none_issued", q_opnd.size(), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        f0.cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_busy", f0.busy, 0);
        check("t6_idle_count", q_opnd.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_cmd_fetch.md
# calc_cmd_fetch

Command sequencer for the calculator: walks the command SRAM from a base address, reads two-byte commands (operand byte, then opcode byte) over the SRAM's combinational read port, and issues each executable command to the ALU with a valid/ready handshake. It sits between the command SRAM (read side only) and the calculator datapath. A HALT opcode, an illegal opcode, or running off the end of memory ends a run.

## Interface
- `ADDR_W`, 8, SRAM address width
- `DATA_W`, 8, SRAM word width
- `BASE_ADDR`, 0, address of the first command's operand byte
- `LAST_ADDR`, 127, highest valid SRAM address
- `clk` in 1: the single clock; all state changes on its rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a run from `BASE_ADDR`; sampled only in IDLE
- `rd_addr` out ADDR_W: SRAM read address, registered
- `rd_data` in DATA_W: SRAM read data, valid in the same cycle as `rd_addr`
- `cmd_valid` out 1: command on `cmd_opcode`/`cmd_operand` is valid
- `cmd_ready` in 1: ALU accepts the command
- `cmd_opcode` out DATA_W: opcode of the issued command
- `cmd_operand` out DATA_W: operand of the issued command
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at the end of a run
- `error` out 1: sticky; set by an illegal opcode or address overrun, cleared by the next accepted `start`

## Operation
- Opcodes: 0x00 NOP (skipped, not issued), 0x01 ADD, 0x02 SUB (both issued), 0x03 HALT (ends the run cleanly; its operand is ignored), any other value is illegal.
- States: IDLE, FETCH_OPND, FETCH_OP, ISSUE, FINISH.
- IDLE: on `start`, set pc = `BASE_ADDR`, `rd_addr` = pc, clear `error`, and go to FETCH_OPND.
- FETCH_OPND: latch `rd_data` into the operand register.
  - If pc == `LAST_ADDR` (no room for an opcode byte): set `error` and go to FINISH.
  - Otherwise set pc, `rd_addr` = pc+1 and go to FETCH_OP.
- FETCH_OP: latch `rd_data` into the opcode register, then decode.
  - ADD/SUB go to ISSUE.
  - NOP advances pc.
  - HALT goes to FINISH.
  - An illegal opcode sets `error` and goes to FINISH.
- Advance pc:
  - If pc+1 > `LAST_ADDR`, set `error` and go to FINISH.
  - Otherwise pc = pc+1, `rd_addr` = pc, and go to FETCH_OPND.
- ISSUE: `cmd_valid` = 1.
  - On `cmd_valid && cmd_ready`, advance pc.
  - `cmd_opcode`/`cmd_operand` are held stable while valid and not ready.
- FINISH: `done` = 1 for exactly one cycle, then go to IDLE.
- `start` is ignored while `busy`.
- The block never writes the SRAM. The integrating top ties SRAM `regWrite` to 0.
- pc arithmetic is ADDR_W-bit, unsigned. The overrun check is done before the increment, so pc never wraps.

## Timing
- Reset (async assert, sync release): state IDLE, pc = `BASE_ADDR`, `rd_addr` = `BASE_ADDR`, `cmd_valid` = 0, `cmd_opcode` = 0, `cmd_operand` = 0, `busy` = 0, `done` = 0, `error` = 0.
- Reset mid-run aborts immediately. No command is issued after reset asserts.
- `start` high at edge N: `busy` is high from N+1, and the first `cmd_valid` rises at N+3 at the earliest.
- Command throughput is 3 cycles per issued command when `cmd_ready` is held high. Each NOP costs 2 cycles.
- `cmd_valid` deasserts in the cycle after the handshake edge.
- `done` pulses one cycle after HALT is decoded. `busy` drops in the same cycle that `done` falls.

## Structure
- Shared package `calc_pkg` holds:
  - the opcode constants `OP_NOP`, `OP_ADD`, `OP_SUB`, `OP_HALT`;
  - the state enum `fetch_state_t`;
  - the default `ADDR_W`/`DATA_W`.
- Single module; no sub-module is warranted. The SRAM model is instantiated only in the bench and top.

## Test plan
- Program 00,01,06,01,02,01,0A,01,0E,03 with `cmd_ready` = 1: ADD operands 0x00, 0x06, 0x02, 0x0A are issued in order, then `done` pulses. `error` = 0 and the HALT operand 0x0E is never issued.
- Same program with `cmd_ready` low for 4 cycles on the second command: `cmd_valid` and `cmd_operand` = 0x06 are held stable, with no skipped or duplicated commands.
- Program 05,00,07,02,00,03: the NOP is not issued, SUB 0x07 is issued, then `done`.
- Program 09,7F: no command is issued, `error` = 1 and `done` pulses. Then `start` again clears `error`.
- No HALT, with `LAST_ADDR` = 9 and all opcodes 0x00: `error` is set on the overrun, `rd_addr` never exceeds 9, and `done` pulses.
- `reset_n` dropped in ISSUE: all outputs reach reset values immediately. `start` pulsed while `busy` is ignored.
